// File: rtl/strobe_timing_pkg.sv
// strobe_timing_pkg: shared state encoding, trigger modes and register width for the strobe timing block.
package strobe_timing_pkg;
  localparam int CFG_W = 16;
  localparam logic [CFG_W-1:0] TRIGMODE_FREERUN = 16'd0;
  localparam logic [CFG_W-1:0] TRIGMODE_EXT = 16'd1;
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, INTEGRATE = 2'd2} state_e;
endpackage

// File: rtl/strobe_timing_gen_ms_prescaler.sv
// ms_prescaler: divides sys_clk down to a one-cycle tick every CYCLES_PER_MS cycles, with sync restart.
module ms_prescaler #(
  parameter int CYCLES_PER_MS = 48000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(CYCLES_PER_MS);
  localparam logic [W-1:0] LAST = W'(CYCLES_PER_MS - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/strobe_timing_gen.sv
// strobe_timing_gen: integration window FSM, single/continuous lamp strobes and external trigger handling
// driven by the SPI timing registers.
module strobe_timing_gen
  import strobe_timing_pkg::*;
#(
  parameter int CYCLES_PER_MS = 48000,
  parameter int MS_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [CFG_W-1:0] cfg_intclock,
  input  logic [CFG_W-1:0] cfg_trigdelay,
  input  logic [CFG_W-1:0] cfg_trigmode,
  input  logic [CFG_W-1:0] cfg_sslowdelay,
  input  logic [CFG_W-1:0] cfg_sshighdelay,
  input  logic [CFG_W-1:0] cfg_lampenable,
  input  logic [CFG_W-1:0] cfg_countbase,
  input  logic [CFG_W-1:0] cfg_strbcount,
  input  logic             ext_trig_in,
  output logic             integ_active,
  output logic             integ_start,
  output logic             integ_end,
  output logic             single_strobe,
  output logic             cont_strobe,
  output logic             trigger,
  output logic             trig_overrun,
  output logic [MS_W-1:0]  ms_count
);
  state_e state;
  logic s1, s2, s3, edge_p, ext_mode, tick, go_int, go_dly, base_tick, lamp, lamp_unused;
  logic [MS_W-1:0] intg_sh, low_sh, high_sh, dly_sh, dly_cnt;
  logic [CFG_W-1:0] cb_cnt, sc_cnt, cb_last;
  assign lamp = cfg_lampenable[0];
  assign lamp_unused = ^cfg_lampenable[CFG_W-1:1];
  assign edge_p = s2 & ~s3;
  assign ext_mode = cfg_trigmode == TRIGMODE_EXT;
  assign integ_active = state == INTEGRATE;
  assign go_dly = state == IDLE && ext_mode && edge_p && cfg_trigdelay != '0;
  assign go_int = (state == IDLE && (!ext_mode || (edge_p && cfg_trigdelay == '0)))
               || (state == DELAY && tick && dly_cnt == dly_sh - 1'b1);
  assign integ_end = integ_active && tick && ms_count == intg_sh - 1'b1;
  assign cb_last = (cfg_countbase == '0) ? '0 : cfg_countbase - 1'b1;
  assign base_tick = cb_cnt >= cb_last;
  ms_prescaler #(.CYCLES_PER_MS(CYCLES_PER_MS)) u_ms (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .restart(go_int | go_dly),
    .tick(tick)
  );
  // trigger is registered so it lines up with the first DELAY cycle
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      {s3, s2, s1} <= '0;
      {integ_start, trigger, trig_overrun, single_strobe} <= '0;
      {intg_sh, low_sh, high_sh, dly_sh, dly_cnt, ms_count} <= '0;
    end else begin
      {s3, s2, s1} <= {s2, s1, ext_trig_in};
      integ_start <= go_int;
      trigger <= state == IDLE && ext_mode && edge_p;
      trig_overrun <= state != IDLE && edge_p;
      single_strobe <= lamp && integ_active && ms_count >= high_sh && ms_count < low_sh;
      state <= go_int ? INTEGRATE : go_dly ? DELAY : integ_end ? IDLE : state;
      if (go_int) begin
        intg_sh <= (cfg_intclock == '0) ? MS_W'(1) : MS_W'(cfg_intclock);
        low_sh <= MS_W'(cfg_sslowdelay);
        high_sh <= MS_W'(cfg_sshighdelay);
        ms_count <= '0;
      end else if (integ_active && tick && ms_count != '1) ms_count <= ms_count + 1'b1;
      if (go_dly) begin
        dly_sh <= MS_W'(cfg_trigdelay);
        dly_cnt <= '0;
      end else if (state == DELAY && tick) dly_cnt <= dly_cnt + 1'b1;
    end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) {cb_cnt, sc_cnt, cont_strobe} <= '0;
    else if (!lamp) {cb_cnt, sc_cnt, cont_strobe} <= '0;
    else begin
      cb_cnt <= base_tick ? '0 : cb_cnt + 1'b1;
      if (cfg_strbcount == '0) sc_cnt <= '0;
      else if (base_tick) sc_cnt <= (sc_cnt >= cfg_strbcount - 1'b1) ? '0 : sc_cnt + 1'b1;
      cont_strobe <= cfg_strbcount != '0 && sc_cnt == '0;
    end
endmodule

// File: tb/tb_strobe_timing_gen.sv
// tb_strobe_timing_gen: table-driven directed checks of frames, strobes, triggers and reset
// for strobe_timing_gen with a 10-cycle ms tick.
module tb_strobe_timing_gen;
  import strobe_timing_pkg::*;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, ext_trig_in = 1'b0;
  logic [15:0] cfg_intclock = 16'd3, cfg_trigdelay = 16'd0, cfg_trigmode = TRIGMODE_FREERUN;
  logic [15:0] cfg_sslowdelay = '0, cfg_sshighdelay = '0, cfg_lampenable = '0;
  logic [15:0] cfg_countbase = '0, cfg_strbcount = '0;
  logic integ_active, integ_start, integ_end, single_strobe, cont_strobe, trigger, trig_overrun;
  logic [15:0] ms_count;
  int checks = 0, failures = 0;

  typedef struct {logic [15:0] intclock; int len; int ms;} frame_vec_t;
  typedef struct {logic [15:0] lamp; logic [15:0] hi; logic [15:0] lo; int cnt; int rise; int fall;} ss_vec_t;
  typedef struct {logic [15:0] cb; logic [15:0] sc; int cnt; int first;} cs_vec_t;
  typedef struct {int wait_c; int len; int endpos; int starts; int ms0; int ms_fin; int rise; int fall; int ss;} res_t;

  strobe_timing_gen #(.CYCLES_PER_MS(10), .MS_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cfg_intclock(cfg_intclock), .cfg_trigdelay(cfg_trigdelay), .cfg_trigmode(cfg_trigmode),
    .cfg_sslowdelay(cfg_sslowdelay), .cfg_sshighdelay(cfg_sshighdelay), .cfg_lampenable(cfg_lampenable),
    .cfg_countbase(cfg_countbase), .cfg_strbcount(cfg_strbcount), .ext_trig_in(ext_trig_in),
    .integ_active(integ_active), .integ_start(integ_start), .integ_end(integ_end),
    .single_strobe(single_strobe), .cont_strobe(cont_strobe), .trigger(trigger),
    .trig_overrun(trig_overrun), .ms_count(ms_count)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic frame(input int mid_at, input logic [15:0] mid_val, output res_t r);
    r.wait_c = -1;
    for (int i = 0; i < 500; i++) begin
      if (integ_start) begin
        r.wait_c = i;
        break;
      end
      step();
    end
    r.len = 0; r.endpos = -1; r.starts = 0; r.rise = -1; r.fall = -1; r.ss = 0; r.ms0 = int'(ms_count);
    if (r.wait_c >= 0)
      while (integ_active && r.len < 2000) begin
        if (r.len == mid_at) cfg_intclock = mid_val;
        if (integ_start) r.starts++;
        if (integ_end) r.endpos = r.len;
        if (single_strobe) begin
          r.ss++;
          if (r.rise < 0) r.rise = r.len;
        end else if (r.rise >= 0 && r.fall < 0) r.fall = r.len;
        r.len++;
        step();
      end
    r.ms_fin = int'(ms_count);
  endtask

  function automatic int outs();
    return int'({integ_active, integ_start, integ_end, single_strobe, cont_strobe, trigger, trig_overrun, ms_count});
  endfunction

  initial begin
    frame_vec_t fv[5];
    ss_vec_t sv[5];
    cs_vec_t cv[5];
    res_t r;
    int n, cnt, first, trg, ovr, sts;
    fv[0] = '{16'd3, 30, 3}; fv[1] = '{16'd1, 10, 1}; fv[2] = '{16'd0, 10, 1};
    fv[3] = '{16'd5, 50, 5}; fv[4] = '{16'd2, 20, 2};
    sv[0] = '{16'd1, 16'd1, 16'd5, 40, 11, 51}; sv[1] = '{16'd0, 16'd1, 16'd5, 0, -1, -1};
    sv[2] = '{16'd1, 16'd5, 16'd1, 0, -1, -1}; sv[3] = '{16'd1, 16'd0, 16'd2, 20, 1, 21};
    sv[4] = '{16'd3, 16'd3, 16'd3, 0, -1, -1};
    cv[0] = '{16'd4, 16'd3, 8, 1}; cv[1] = '{16'd4, 16'd0, 0, -1}; cv[2] = '{16'd0, 16'd2, 12, 1};
    cv[3] = '{16'd2, 16'd1, 24, 1}; cv[4] = '{16'd3, 16'd4, 6, 1};

    #3;
    chk("reset_outputs", outs(), 0);
    repeat (3) step();
    chk("reset_held_outputs", outs(), 0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cfg_intclock = fv[i].intclock;
      frame(-1, 16'd0, r);
      chk($sformatf("frame%0d_gap", i), r.wait_c, 1);
      chk($sformatf("frame%0d_len", i), r.len, fv[i].len);
      chk($sformatf("frame%0d_endpos", i), r.endpos, fv[i].len - 1);
      chk($sformatf("frame%0d_starts", i), r.starts, 1);
      chk($sformatf("frame%0d_ms0", i), r.ms0, 0);
      chk($sformatf("frame%0d_msfin", i), r.ms_fin, fv[i].ms);
    end

    cfg_intclock = 16'd3;
    frame(5, 16'd5, r);
    chk("midchange_cur_len", r.len, 30);
    chk("midchange_cur_ms", r.ms_fin, 3);
    frame(-1, 16'd0, r);
    chk("midchange_next_len", r.len, 50);
    chk("midchange_next_ms", r.ms_fin, 5);

    cfg_intclock = 16'd6;
    for (int i = 0; i < 5; i++) begin
      cfg_lampenable = sv[i].lamp;
      cfg_sshighdelay = sv[i].hi;
      cfg_sslowdelay = sv[i].lo;
      frame(-1, 16'd0, r);
      chk($sformatf("ss%0d_len", i), r.len, 60);
      chk($sformatf("ss%0d_cnt", i), r.ss, sv[i].cnt);
      chk($sformatf("ss%0d_rise", i), r.rise, sv[i].rise);
      chk($sformatf("ss%0d_fall", i), r.fall, sv[i].fall);
    end

    cfg_lampenable = '0;
    cfg_trigmode = TRIGMODE_EXT;
    cfg_trigdelay = 16'd2;
    cfg_intclock = 16'd1;
    repeat (5) step();
    chk("ext_idle_no_frame", int'(integ_active), 0);
    ext_trig_in = 1'b1;
    n = 0;
    while (!trigger && n < 20) begin
      step();
      n++;
    end
    chk("trig_latency", n, 3);
    n = 0; trg = 0;
    while (!integ_start && n < 100) begin
      step();
      n++;
      if (trigger) trg++;
    end
    chk("trig_to_start", n, 20);
    chk("trig_single_pulse", trg, 0);
    ext_trig_in = 1'b0;
    repeat (2) step();
    ext_trig_in = 1'b1;
    trg = 0; ovr = 0; sts = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (trigger) trg++;
      if (trig_overrun) ovr++;
      if (integ_start) sts++;
    end
    chk("overrun_pulses", ovr, 1);
    chk("overrun_no_trigger", trg, 0);
    chk("overrun_no_new_frame", sts, 0);

    for (int i = 0; i < 5; i++) begin
      cfg_lampenable = '0;
      step();
      cfg_countbase = cv[i].cb;
      cfg_strbcount = cv[i].sc;
      cfg_lampenable = 16'd1;
      cnt = 0; first = -1;
      for (int s = 1; s <= 24; s++) begin
        step();
        if (cont_strobe) begin
          cnt++;
          if (first < 0) first = s;
        end
      end
      chk($sformatf("cs%0d_cnt", i), cnt, cv[i].cnt);
      chk($sformatf("cs%0d_first", i), first, cv[i].first);
    end
    cfg_lampenable = '0;
    cfg_countbase = 16'd4;
    cfg_strbcount = 16'd3;
    step();
    cfg_lampenable = 16'hFFFE;
    step();
    chk("cs_lamp_bit0_only", int'(cont_strobe), 0);
    cfg_lampenable = 16'd1;
    repeat (2) step();
    chk("cs_lamp_on", int'(cont_strobe), 1);
    cfg_lampenable = '0;
    step();
    chk("cs_lamp_drop", int'(cont_strobe), 0);

    cfg_lampenable = 16'd1;
    cfg_sshighdelay = 16'd0;
    cfg_sslowdelay = 16'd3;
    cfg_intclock = 16'd3;
    cfg_trigmode = TRIGMODE_FREERUN;
    n = 0;
    while (!integ_start && n < 100) begin
      step();
      n++;
    end
    repeat (15) step();
    chk("pre_reset_active", int'(integ_active), 1);
    chk("pre_reset_single", int'(single_strobe), 1);
    chk("pre_reset_ms", int'(ms_count), 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 0);
    repeat (2) step();
    sys_rst_n = 1'b1;
    step();
    chk("post_reset_start", int'(integ_start), 1);
    chk("post_reset_active", int'(integ_active), 1);
    chk("post_reset_ms", int'(ms_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
